// File: rtl/stack_ram_arbiter.sv
// Round-robin two-port controller for a registered-output stack RAM.
// Tracks stack depth and sequences PUSH/POP/PEEK/CLEAR with a req/ack handshake per port.
`timescale 1ns/1ps
module stack_ram_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  resetn,
  input  logic                  a_req,
  input  logic [1:0]            a_op,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_ack,
  output logic                  a_err,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic [1:0]            b_op,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_ack,
  output logic                  b_err,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_wen,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [ADDR_WIDTH:0]   depth
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR   = 3'd1,
    S_RD0  = 3'd2,
    S_RD1  = 3'd3,
    S_ACK  = 3'd4
  } state_e;

  localparam logic [1:0] OP_PUSH  = 2'b00;
  localparam logic [1:0] OP_POP   = 2'b01;
  localparam logic [1:0] OP_PEEK  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic [ADDR_WIDTH:0]   DEPTH_ZERO = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH:0]   DEPTH_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO  = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO  = {DATA_WIDTH{1'b0}};

  state_e                state_q, state_d;
  logic                  last_gnt_b_q, last_gnt_b_d;
  logic                  gnt_b_q, gnt_b_d;
  logic [1:0]            op_q, op_d;
  logic [ADDR_WIDTH:0]   depth_q, depth_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
  logic                  ram_wen_q, ram_wen_d;
  logic                  a_ack_q, a_ack_d, a_err_q, a_err_d;
  logic                  b_ack_q, b_ack_d, b_err_q, b_err_d;
  logic [DATA_WIDTH-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;

  logic                  req_any;
  logic                  sel_b;
  logic [1:0]            sel_op;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  full;
  logic                  empty;

  // Round-robin selection: on a tie the port that did not win last time is chosen.
  always_comb begin
    req_any   = a_req | b_req;
    sel_b     = b_req & (~a_req | ~last_gnt_b_q);
    sel_op    = sel_b ? b_op : a_op;
    sel_wdata = sel_b ? b_wdata : a_wdata;
    full      = depth_q[ADDR_WIDTH];
    empty     = (depth_q == DEPTH_ZERO);
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_any) begin
          case (sel_op)
            OP_PUSH:  state_d = full  ? S_ACK : S_WR;
            OP_POP:   state_d = empty ? S_ACK : S_RD0;
            OP_PEEK:  state_d = empty ? S_ACK : S_RD0;
            OP_CLEAR: state_d = S_ACK;
            default:  state_d = S_ACK;
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WR:    state_d = S_ACK;
      S_RD0:   state_d = S_RD1;
      S_RD1:   state_d = S_ACK;
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and registered-output next values; acks and errs default low so they pulse once.
  always_comb begin
    last_gnt_b_d = last_gnt_b_q;
    gnt_b_d      = gnt_b_q;
    op_d         = op_q;
    depth_d      = depth_q;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    ram_wen_d    = 1'b0;
    a_ack_d      = 1'b0;
    a_err_d      = 1'b0;
    b_ack_d      = 1'b0;
    b_err_d      = 1'b0;
    a_rdata_d    = a_rdata_q;
    b_rdata_d    = b_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_any) begin
          last_gnt_b_d = sel_b;
          gnt_b_d      = sel_b;
          op_d         = sel_op;
          case (sel_op)
            OP_PUSH: begin
              if (full) begin
                a_ack_d = ~sel_b;
                a_err_d = ~sel_b;
                b_ack_d = sel_b;
                b_err_d = sel_b;
              end else begin
                ram_addr_d  = depth_q[ADDR_WIDTH-1:0];
                ram_wdata_d = sel_wdata;
                ram_wen_d   = 1'b1;
              end
            end
            OP_POP, OP_PEEK: begin
              if (empty) begin
                a_ack_d = ~sel_b;
                a_err_d = ~sel_b;
                b_ack_d = sel_b;
                b_err_d = sel_b;
              end else begin
                // depth 2**ADDR_WIDTH wraps its low bits to zero, so minus one still hits the top cell
                ram_addr_d = depth_q[ADDR_WIDTH-1:0] - ADDR_ONE;
              end
            end
            OP_CLEAR: begin
              depth_d = DEPTH_ZERO;
              a_ack_d = ~sel_b;
              b_ack_d = sel_b;
            end
            default: begin
              a_ack_d = ~sel_b;
              a_err_d = ~sel_b;
              b_ack_d = sel_b;
              b_err_d = sel_b;
            end
          endcase
        end else begin
          op_d = op_q;
        end
      end
      S_WR: begin
        depth_d = depth_q + DEPTH_ONE;
        a_ack_d = ~gnt_b_q;
        b_ack_d = gnt_b_q;
      end
      S_RD0: begin
        op_d = op_q;
      end
      S_RD1: begin
        if (gnt_b_q) begin
          b_rdata_d = ram_rdata;
        end else begin
          a_rdata_d = ram_rdata;
        end
        if (op_q == OP_POP) begin
          depth_d = depth_q - DEPTH_ONE;
        end else begin
          depth_d = depth_q;
        end
        a_ack_d = ~gnt_b_q;
        b_ack_d = gnt_b_q;
      end
      S_ACK: begin
        op_d = op_q;
      end
      default: begin
        op_d = op_q;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge CLK) begin
    if (!resetn) begin
      last_gnt_b_q <= 1'b1;
      gnt_b_q      <= 1'b0;
      op_q         <= OP_PUSH;
      depth_q      <= DEPTH_ZERO;
      ram_addr_q   <= ADDR_ZERO;
      ram_wdata_q  <= DATA_ZERO;
      ram_wen_q    <= 1'b0;
      a_ack_q      <= 1'b0;
      a_err_q      <= 1'b0;
      b_ack_q      <= 1'b0;
      b_err_q      <= 1'b0;
      a_rdata_q    <= DATA_ZERO;
      b_rdata_q    <= DATA_ZERO;
    end else begin
      last_gnt_b_q <= last_gnt_b_d;
      gnt_b_q      <= gnt_b_d;
      op_q         <= op_d;
      depth_q      <= depth_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      ram_wen_q    <= ram_wen_d;
      a_ack_q      <= a_ack_d;
      a_err_q      <= a_err_d;
      b_ack_q      <= b_ack_d;
      b_err_q      <= b_err_d;
      a_rdata_q    <= a_rdata_d;
      b_rdata_q    <= b_rdata_d;
    end
  end

  assign a_ack     = a_ack_q;
  assign a_err     = a_err_q;
  assign a_rdata   = a_rdata_q;
  assign b_ack     = b_ack_q;
  assign b_err     = b_err_q;
  assign b_rdata   = b_rdata_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_wen   = ram_wen_q;
  assign depth     = depth_q;

endmodule
